// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command-driven up-counter with one-shot/periodic terminal events
// Optional tick prescaler is enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
  parameter int Size = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [Size-1:0] cmd_data,
  input  logic            periodic,
  input  logic            done_ack,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [7:0]      prescale,
`endif
  output logic [Size-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e          state_q, state_d;
  logic [Size-1:0] count_q, count_d;
  logic [Size-1:0] limit_q, limit_d;
  logic            periodic_q, periodic_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;
  logic            ready_q, ready_d;
  logic            accept;
  logic            ps_hit;
  logic            tick;
  logic            terminal;

  assign accept = cmd_valid && ready_q;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [7:0] ps_q, ps_d;

  assign ps_hit = (ps_q == prescale);

  // Prescaler only advances in RUN, so PAUSED naturally holds it.
  always_comb begin
    ps_d = ps_q;
    if (state_q == ST_RUN) begin
      ps_d = ps_hit ? 8'd0 : ps_q + 8'd1;
    end
    if (accept && ((cmd_op == OP_CLEAR) ||
                   ((cmd_op == OP_START) && (state_q == ST_IDLE)))) begin
      ps_d = 8'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q <= 8'd0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign ps_hit = 1'b1;
`endif

  assign tick     = (state_q == ST_RUN) && ps_hit;
  assign terminal = tick && (count_q == limit_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    ready_d    = !accept;

    if (tick) begin
      if (terminal) begin
        if (periodic_q) begin
          count_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        count_d = count_q + Size'(1);
      end
    end

    // An event landing on an ack keeps done set and is not counted as lost.
    if (terminal) begin
      done_d = 1'b1;
      if (done_q && !done_ack) begin
        overrun_d = 1'b1;
      end
    end else if (done_ack) begin
      done_d = 1'b0;
    end

    // Commands are applied last so they take priority over the tick's state/count.
    if (accept) begin
      case (cmd_op)
        OP_LOAD: begin
          limit_d = cmd_data;
        end
        OP_START: begin
          if (state_q == ST_IDLE) begin
            count_d    = '0;
            periodic_d = periodic;
          end else if (state_q == ST_RUN) begin
            count_d = '0;
          end
          state_d = ST_RUN;
        end
        OP_STOP: begin
          if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
            count_d = count_q;
          end
        end
        OP_CLEAR: begin
          state_d   = ST_IDLE;
          count_d   = '0;
          done_d    = 1'b0;
          overrun_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      limit_q    <= '1;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl with a behavioural reference model
// Honours COUNTER_CTRL_PRESCALE_EN when defined.
module tb_counter_ctrl;

  localparam int Size   = 5;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;

  logic            clock     = 1'b0;
  logic            reset     = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_op    = 2'd0;
  logic [Size-1:0] cmd_data  = '0;
  logic            periodic  = 1'b0;
  logic            done_ack  = 1'b0;
  logic            cmd_ready;
  logic [Size-1:0] count;
  logic            busy;
  logic            done;
  logic            overrun;
`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [7:0]      prescale  = 8'd0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int m_state = M_IDLE;
  int m_count = 0;
  int m_limit = (1 << Size) - 1;
  int m_ps    = 0;
  bit m_per   = 1'b0;
  bit m_done  = 1'b0;
  bit m_ovr   = 1'b0;
  bit m_ready = 1'b1;

  always #5 clock = ~clock;

  counter_ctrl #(.Size(Size)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .periodic  (periodic),
    .done_ack  (done_ack),
`ifdef COUNTER_CTRL_PRESCALE_EN
    .prescale  (prescale),
`endif
    .count     (count),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  // Reference: what the next edge should produce from the current inputs.
  task automatic model_step();
    int n_state, n_count, n_limit, n_ps, pre;
    bit n_per, n_done, n_ovr, acc, tk, term;
    if (reset) begin
      m_state = M_IDLE; m_count = 0; m_limit = (1 << Size) - 1; m_ps = 0;
      m_per = 0; m_done = 0; m_ovr = 0; m_ready = 1;
      return;
    end
    pre = 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
    pre = int'(prescale);
`endif
    acc = cmd_valid && m_ready;
    n_state = m_state; n_count = m_count; n_limit = m_limit; n_ps = m_ps;
    n_per = m_per; n_done = m_done; n_ovr = m_ovr;
    tk = (m_state == M_RUN) && (m_ps == pre);
    if (m_state == M_RUN) n_ps = tk ? 0 : (m_ps + 1) % 256;
    term = tk && (m_count == m_limit);
    if (tk) begin
      if (!term) n_count = (m_count + 1) % (1 << Size);
      else if (m_per) n_count = 0;
      else n_state = M_IDLE;
    end
    if (term) begin
      n_done = 1;
      if (m_done && !done_ack) n_ovr = 1;
    end else if (done_ack) begin
      n_done = 0;
    end
    if (acc) begin
      case (cmd_op)
        2'd0: n_limit = int'(cmd_data);
        2'd1: begin
          if (m_state == M_IDLE) begin n_count = 0; n_per = periodic; n_ps = 0; end
          else if (m_state == M_RUN) n_count = 0;
          n_state = M_RUN;
        end
        2'd2: if (m_state == M_RUN) begin n_state = M_PAUS; n_count = m_count; end
        default: begin n_state = M_IDLE; n_count = 0; n_done = 0; n_ovr = 0; n_ps = 0; end
      endcase
    end
    m_state = n_state; m_count = n_count; m_limit = n_limit; m_ps = n_ps;
    m_per = n_per; m_done = n_done; m_ovr = n_ovr; m_ready = !acc;
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [Size-1:0] data, input logic per);
    int waits;
    waits = 0;
    cmd_valid = 1'b0;
    while (cmd_ready !== 1'b1 && waits < 4) begin
      tick_clk();
      waits++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_wait got %b want 1", cmd_ready);
    end
    cmd_op = op; cmd_data = data; periodic = per; cmd_valid = 1'b1;
    tick_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_clk(); tick_clk();
    reset = 1'b0;
    n_cmp++;
    if ({cmd_ready, busy, done, overrun, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b busy=%b done=%b ovr=%b cnt=%0d want 1 0 0 0 0",
               cmd_ready, busy, done, overrun, count);
    end
    send_cmd(2'd1, '0, 1'b0);
    for (int j = 0; j < 31; j++) tick_clk();
    n_cmp++;
    if ({busy, done, count} !== {1'b1, 1'b0, 5'd31}) begin
      n_fail++;
      $display("FAIL reset_limit_run got busy=%b done=%b cnt=%0d want 1 0 31", busy, done, count);
    end
    tick_clk();
    n_cmp++;
    if ({busy, done, count} !== {1'b0, 1'b1, 5'd31}) begin
      n_fail++;
      $display("FAIL reset_limit_term got busy=%b done=%b cnt=%0d want 0 1 31", busy, done, count);
    end
    cmd_op = 2'd1; cmd_valid = 1'b1; reset = 1'b1;
    tick_clk();
    cmd_valid = 1'b0; reset = 1'b0;
    n_cmp++;
    if ({cmd_ready, busy, done, count} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_over_cmd got rdy=%b busy=%b done=%b cnt=%0d want 1 0 0 0",
               cmd_ready, busy, done, count);
    end
    send_cmd(2'd0, 5'd2, 1'b0);
    send_cmd(2'd1, '0, 1'b0);
    tick_clk(); tick_clk();
    reset = 1'b1;
    tick_clk();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) tick_clk();
    n_cmp++;
    if ({busy, done, overrun, count} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_run got busy=%b done=%b ovr=%b cnt=%0d want 0 0 0 0",
               busy, done, overrun, count);
    end
  endtask

  task automatic test_one_shot();
    send_cmd(2'd3, '0, 1'b0);
    send_cmd(2'd0, 5'd3, 1'b0);
    send_cmd(2'd1, '0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if ({busy, done, count} !== {1'b1, 1'b0, 5'(j)}) begin
        n_fail++;
        $display("FAIL oneshot_seq%0d got busy=%b done=%b cnt=%0d want 1 0 %0d", j, busy, done, count, j);
      end
      tick_clk();
    end
    n_cmp++;
    if ({busy, done, overrun, count} !== {1'b0, 1'b1, 1'b0, 5'd3}) begin
      n_fail++;
      $display("FAIL oneshot_term got busy=%b done=%b ovr=%b cnt=%0d want 0 1 0 3", busy, done, overrun, count);
    end
    tick_clk(); tick_clk();
    n_cmp++;
    if ({busy, done, count} !== {1'b0, 1'b1, 5'd3}) begin
      n_fail++;
      $display("FAIL oneshot_hold got busy=%b done=%b cnt=%0d want 0 1 3", busy, done, count);
    end
    done_ack = 1'b1;
    tick_clk();
    done_ack = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_ack got done=%b want 0", done);
    end
  endtask

  task automatic test_periodic();
    logic [Size-1:0] exp_cnt [7];
    logic            exp_done[7];
    logic            exp_ovr [7];
    exp_cnt  = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2, 5'd0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ovr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    send_cmd(2'd3, '0, 1'b0);
    send_cmd(2'd0, 5'd2, 1'b0);
    send_cmd(2'd1, '0, 1'b1);
    for (int j = 0; j < 7; j++) begin
      n_cmp++;
      if ({busy, done, overrun, count} !== {1'b1, exp_done[j], exp_ovr[j], exp_cnt[j]}) begin
        n_fail++;
        $display("FAIL periodic_seq%0d got busy=%b done=%b ovr=%b cnt=%0d want 1 %b %b %0d",
                 j, busy, done, overrun, count, exp_done[j], exp_ovr[j], exp_cnt[j]);
      end
      if (j < 6) tick_clk();
    end
  endtask

  task automatic test_pause_resume();
    send_cmd(2'd3, '0, 1'b0);
    send_cmd(2'd0, 5'd10, 1'b0);
    send_cmd(2'd1, '0, 1'b0);
    tick_clk(); tick_clk();
    send_cmd(2'd2, '0, 1'b0);
    for (int j = 0; j < 5; j++) tick_clk();
    n_cmp++;
    if ({busy, count} !== {1'b0, 5'd2}) begin
      n_fail++;
      $display("FAIL pause_hold got busy=%b cnt=%0d want 0 2", busy, count);
    end
    send_cmd(2'd1, '0, 1'b0);
    n_cmp++;
    if ({busy, count} !== {1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL pause_resume got busy=%b cnt=%0d want 1 2", busy, count);
    end
    tick_clk();
    n_cmp++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL pause_next got cnt=%0d want 3", count);
    end
  endtask

  task automatic test_clear_on_terminal();
    send_cmd(2'd3, '0, 1'b0);
    send_cmd(2'd0, 5'd1, 1'b0);
    send_cmd(2'd1, '0, 1'b1);
    tick_clk();
    send_cmd(2'd3, '0, 1'b0);
    n_cmp++;
    if ({busy, done, overrun, count} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL clear_on_term got busy=%b done=%b ovr=%b cnt=%0d want 0 0 0 0", busy, done, overrun, count);
    end
  endtask

  task automatic test_limit_zero();
    send_cmd(2'd3, '0, 1'b0);
    send_cmd(2'd0, 5'd0, 1'b0);
    send_cmd(2'd1, '0, 1'b1);
    tick_clk();
    n_cmp++;
    if ({busy, done, overrun, count} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL limit0_first got busy=%b done=%b ovr=%b cnt=%0d want 1 1 0 0", busy, done, overrun, count);
    end
    done_ack = 1'b1;
    tick_clk();
    done_ack = 1'b0;
    n_cmp++;
    if ({done, overrun, count} !== {1'b1, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL limit0_ack_coincide got done=%b ovr=%b cnt=%0d want 1 0 0", done, overrun, count);
    end
    tick_clk();
    n_cmp++;
    if ({done, overrun, count} !== {1'b1, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL limit0_overrun got done=%b ovr=%b cnt=%0d want 1 1 0", done, overrun, count);
    end
    send_cmd(2'd3, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy_seq;
    int acc;
    acc = 0;
    cmd_valid = 1'b0;
    tick_clk();
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 5'(7 + i);
      rdy_seq[3-i] = cmd_ready;
      if (cmd_ready === 1'b1) acc++;
      tick_clk();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (rdy_seq !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b_ready_seq got %b want 1010", rdy_seq);
    end
    n_cmp++;
    if (acc != 2) begin
      n_fail++;
      $display("FAIL b2b_accepts got %0d want 2", acc);
    end
  endtask

`ifdef COUNTER_CTRL_PRESCALE_EN
  task automatic test_prescale();
    send_cmd(2'd3, '0, 1'b0);
    prescale = 8'd2;
    send_cmd(2'd0, 5'd4, 1'b0);
    send_cmd(2'd1, '0, 1'b0);
    for (int j = 1; j <= 14; j++) begin
      tick_clk();
      if (j % 3 == 0 || j == 14) begin
        n_cmp++;
        if ({busy, done, count} !== {1'b1, 1'b0, 5'(j / 3)}) begin
          n_fail++;
          $display("FAIL prescale_e%0d got busy=%b done=%b cnt=%0d want 1 0 %0d", j, busy, done, count, j / 3);
        end
      end
    end
    tick_clk();
    n_cmp++;
    if ({busy, done, count} !== {1'b0, 1'b1, 5'd4}) begin
      n_fail++;
      $display("FAIL prescale_term got busy=%b done=%b cnt=%0d want 0 1 4", busy, done, count);
    end
    prescale = 8'd0;
    send_cmd(2'd3, '0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [Size+3:0] exp;
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = ($urandom_range(0, 3) == 0) ? Size'($urandom_range(0, 31)) : Size'($urandom_range(0, 5));
      periodic  = ($urandom_range(0, 1) == 1);
      done_ack  = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      tick_clk();
      exp = {m_ready, (m_state == M_RUN), m_done, m_ovr, Size'(m_count)};
      n_cmp++;
      if ({cmd_ready, busy, done, overrun, count} !== exp) begin
        n_fail++;
        $display("FAIL random_c%0d got rdy/busy/done/ovr/cnt=%b want %b", i,
                 {cmd_ready, busy, done, overrun, count}, exp);
      end
    end
    cmd_valid = 1'b0; done_ack = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause_resume();
    test_clear_on_terminal();
    test_limit_zero();
    test_back_to_back();
`ifdef COUNTER_CTRL_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter Size, default 5: width of count and limit.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command can be accepted this cycle.
REQ-006 SHALL have port cmd_op  input  2  opcode: 00 LOAD, 01 START, 10 STOP, 11 CLEAR.
REQ-007 SHALL have port cmd_data  input  Size  new limit, used by LOAD only.
REQ-008 SHALL have port periodic  input  1  mode, sampled only when START is accepted from IDLE.
REQ-009 SHALL have port done_ack  input  1  clears done.
REQ-010 SHALL have port count  output  Size  current count value.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  sticky terminal-event flag.
REQ-013 SHALL have port overrun  output  1  sticky lost-event flag.

Function
REQ-014 SHALL accept a command only on an edge where cmd_valid and cmd_ready are both 1.
REQ-015 SHALL drive cmd_ready 0 for exactly one cycle after each accepted command and 1 otherwise.
REQ-016 SHALL implement states IDLE, RUN and PAUSED.
REQ-017 SHALL make LOAD write cmd_data to the limit register in any state, without changing state or count; the new limit applies from the next cycle.
REQ-018 SHALL make START in IDLE set count to 0, latch periodic and enter RUN.
REQ-019 SHALL make START in RUN restart count at 0; START in PAUSED SHALL resume RUN with count unchanged.
REQ-020 SHALL make STOP in RUN enter PAUSED with count held; STOP in IDLE or PAUSED SHALL have no effect.
REQ-021 SHALL make CLEAR from any state enter IDLE with count, done and overrun all 0; the limit register SHALL be unchanged.
REQ-022 SHALL define a tick as every cycle in RUN (see REQ-032 for the prescaled case); there SHALL be no tick in IDLE or PAUSED.
REQ-023 SHALL, on a tick with count != limit, increment count by 1.
REQ-024 SHALL, on a tick with count == limit, raise a terminal event and then:
- one-shot: enter IDLE with count held at limit;
- periodic: set count to 0 and stay in RUN.
REQ-025 SHALL set done to 1 on the edge after a terminal event; done SHALL hold until a done_ack edge.
REQ-026 SHALL set overrun if a terminal event occurs while done=1 and done_ack=0.
REQ-027 SHALL, when done_ack and a terminal event coincide, leave done=1 and not set overrun.
REQ-028 SHALL, for limit=0, raise a terminal event on every tick with count remaining 0.
REQ-029 SHALL resolve a command accepted on the same edge as a terminal event as follows:
- CLEAR: CLEAR wins and the event is discarded;
- START, STOP or LOAD: the event still updates done/overrun, while state and count follow the command;
- LOAD: the terminal compare uses the old limit.

Reset
REQ-030 SHALL, while reset=1 at an edge, enter IDLE with count=0, done=0, overrun=0, busy=0, cmd_ready=1 and limit={Size{1}}; reset SHALL override any command.
REQ-031 SHALL, on reset mid-RUN, abandon the sequence immediately; no done or overrun results from it.

Configuration
REQ-032 SHALL, with COUNTER_CTRL_PRESCALE_EN defined:
- add port prescale  input  8;
- tick once every prescale+1 cycles in RUN;
- reset the prescaler on reset, CLEAR and START-from-IDLE, and hold it in PAUSED.
REQ-033 SHALL, without COUNTER_CTRL_PRESCALE_EN, omit the prescale port and tick every RUN cycle.

Verification (Size=5, macro undefined unless stated)
REQ-034 SHALL cover one-shot: LOAD 3, then START with periodic=0 at edge k -> count 0,1,2,3 after edges k..k+3; done=1 and busy=0 after k+4; count holds at 3.
REQ-035 SHALL cover periodic: LOAD 2, START with periodic=1 -> count sequence 0,1,2,0,1,2,0; done set after the first wrap; with no ack, overrun=1 after the second wrap.
REQ-036 SHALL cover pause/resume: STOP accepted when count=2; hold 5 cycles -> count stays 2 and busy=0; START -> count 3 on the next edge.
REQ-037 SHALL cover CLEAR on terminal: limit 1, periodic, CLEAR accepted on the terminal edge -> IDLE with count=0, done=0 and overrun=0.
REQ-038 SHALL cover back-to-back commands: cmd_valid held high for 4 cycles -> exactly 2 commands accepted, with cmd_ready toggling 1,0,1,0.
REQ-039 SHALL cover prescale: with the macro defined, prescale=2 and LOAD 4 one-shot -> count increments every 3 cycles; done=1 on the edge after the 5th tick (count=4 compared).
